// File: rtl/binary_to_bcd_seq_if.sv
// Handshake bundle for binary_to_bcd_seq.
// master: upstream/downstream side (drives bin/in_valid/out_ready).
// slave:  the converter.
// Optional macro: BIN2BCD_OVF_EN adds the ovf signal.
interface binary_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_OVF_EN
    logic                  ovf;

    modport master (output in_valid, bin, out_ready,
                    input  in_ready, out_valid, bcd, ovf);
    modport slave  (input  in_valid, bin, out_ready,
                    output in_ready, out_valid, bcd, ovf);
`else
    modport master (output in_valid, bin, out_ready,
                    input  in_ready, out_valid, bcd);
    modport slave  (input  in_valid, bin, out_ready,
                    output in_ready, out_valid, bcd);
`endif
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// IDLE accepts a value, CONV runs WIDTH shift/add-3 steps, DONE holds the
// result until the consumer takes it. Result is bin mod 10^DIGITS.
// Optional macro: BIN2BCD_OVF_EN adds a sticky overflow flag (bus.ovf) that
// flags any 1 bit shifted out of the top digit.
module binary_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    binary_to_bcd_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    typedef logic [SW-1:0] scr_t;

    state_t                  state, state_nxt;
    logic [WIDTH-1:0]        sr;
    logic [DIGITS-1:0][3:0]  scr;
    logic [DIGITS-1:0][3:0]  adj;
    logic [CW-1:0]           cnt;
    logic [SW-1:0]           bcd_r;
    logic [SW-1:0]           adj_flat;
    logic [SW-1:0]           scr_shift;
    logic                    last;
    logic                    in_ready;
    logic                    out_valid;

    // Add-3 correction on every digit in parallel, using pre-shift values.
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign adj[d] = (scr[d] >= 4'd5) ? scr[d] + 4'd3 : scr[d];
    end

    assign adj_flat  = adj;
    // Shift the corrected scratch left, pulling in the next binary MSB;
    // the top scratch bit falls off (mod 10^DIGITS).
    assign scr_shift = scr_t'({adj_flat, sr[WIDTH-1]});
    assign last      = (cnt == CW'(WIDTH - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.bcd       = bcd_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; handshake outputs decode from state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = CONV;
            end
            CONV: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, shift/add during CONV, capture on last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            scr   <= '0;
            cnt   <= '0;
            bcd_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sr  <= bus.bin;
                    scr <= '0;
                    cnt <= '0;
                end
                CONV: begin
                    sr  <= sr << 1;
                    scr <= scr_shift;
                    cnt <= cnt + CW'(1);
                    if (last) bcd_r <= scr_shift;
                end
                default: ;
            endcase
        end
    end

`ifdef BIN2BCD_OVF_EN
    logic ovf_r;
    assign bus.ovf = ovf_r;

    // Sticky overflow: any 1 leaving the top digit during conversion.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_r <= 1'b0;
        else if (state == IDLE && bus.in_valid)
            ovf_r <= 1'b0;
        else if (state == CONV)
            ovf_r <= ovf_r | adj_flat[SW-1];
    end
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq: several parameterisations share one
// clock/reset; each scenario task drives and checks its own instance.
module tb_binary_to_bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    binary_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) b8  ();
    binary_to_bcd_seq_if #(.WIDTH(4),  .DIGITS(2)) b4  ();
    binary_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) b16 ();

    binary_to_bcd_seq #(.WIDTH(8),  .DIGITS(3)) u8  (.clk(clk), .rst(rst), .bus(b8));
    binary_to_bcd_seq #(.WIDTH(4),  .DIGITS(2)) u4  (.clk(clk), .rst(rst), .bus(b4));
    binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (.clk(clk), .rst(rst), .bus(b16));

`ifdef BIN2BCD_OVF_EN
    binary_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) bo ();
    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) uo (.clk(clk), .rst(rst), .bus(bo));
`endif

    // Accept v on the 8-bit/3-digit instance with out_ready high and return
    // the result plus the number of edges from accept to out_valid.
    task automatic run8(input logic [7:0] v, output logic [11:0] res, output int lat);
        @(negedge clk);
        b8.bin = v; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = b8.bcd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_run++; if (b8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8 got %b want 1", b8.in_ready); end
        n_run++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8 got %b want 0", b8.out_valid); end
        n_run++; if (b8.bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd8 got %h want 000", b8.bcd); end
        n_run++; if (b4.bcd !== 8'h00 || b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_4 got bcd=%h ov=%b want 00/0", b4.bcd, b4.out_valid); end
        n_run++; if (b16.bcd !== 20'h0 || b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_16 got bcd=%h ir=%b want 0/1", b16.bcd, b16.in_ready); end
`ifdef BIN2BCD_OVF_EN
        n_run++; if (bo.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bo.ovf); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [11:0] res;
        int lat;
        run8(8'd255, res, lat);
        n_run++; if (lat !== 8) begin n_fail++; $display("FAIL latency255 got %0d want 8", lat); end
        n_run++; if (res !== 12'h255) begin n_fail++; $display("FAIL bcd255 got %h want 255", res); end
        @(negedge clk);
        n_run++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin n_fail++; $display("FAIL one_cycle_valid got ov=%b ir=%b want 0/1", b8.out_valid, b8.in_ready); end
        run8(8'd0, res, lat);
        n_run++; if (res !== 12'h000) begin n_fail++; $display("FAIL bcd0 got %h want 000", res); end
        run8(8'd109, res, lat);
        n_run++; if (res !== 12'h109) begin n_fail++; $display("FAIL bcd109 got %h want 109", res); end
    endtask

    task automatic test_sweep4();
        logic [7:0] exp4 [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                  8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        int n;
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            b4.bin = 4'(v); b4.in_valid = 1'b1; b4.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            b4.in_valid = 1'b0;
            n = 0;
            while (!b4.out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            n_run++; if (b4.bcd !== exp4[v] || n !== 4) begin n_fail++; $display("FAIL sweep4[%0d] got bcd=%h lat=%0d want %h lat=4", v, b4.bcd, n, exp4[v]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        b8.bin = 8'd128; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b8.bin = 8'd99;          // stays valid through CONV; must be ignored
        n = 0;
        while (!b8.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if (b8.out_valid !== 1'b1 || b8.bcd !== 12'h128 || b8.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall[%0d] got ov=%b bcd=%h ir=%b want 1/128/0", i, b8.out_valid, b8.bcd, b8.in_ready);
            end
            b8.in_valid = i[0];
            @(negedge clk);
        end
        b8.in_valid = 1'b0; b8.out_ready = 1'b1;
        @(negedge clk);
        n_run++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.bcd !== 12'h128) begin n_fail++; $display("FAIL stall_release got ov=%b ir=%b bcd=%h want 0/1/128", b8.out_valid, b8.in_ready, b8.bcd); end
        repeat (12) @(negedge clk);
        n_run++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL ignored_input got ov=%b want 0", b8.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] res;
        int lat;
        bit seen;
        @(negedge clk);
        b8.bin = 8'd200; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b8.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_run++; if (b8.out_valid !== 1'b0 || b8.bcd !== 12'h000 || b8.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset got ov=%b bcd=%h ir=%b want 0/000/1", b8.out_valid, b8.bcd, b8.in_ready); end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (b8.out_valid) seen = 1'b1;
        end
        n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL no_pulse_after_reset got %b want 0", seen); end
        run8(8'd7, res, lat);
        n_run++; if (res !== 12'h007) begin n_fail++; $display("FAIL after_reset7 got %h want 007", res); end
    endtask

`ifdef BIN2BCD_OVF_EN
    task automatic test_overflow();
        logic [7:0] vals [2] = '{8'd200, 8'd99};
        logic [7:0] expb [2] = '{8'h00, 8'h99};
        logic       expo [2] = '{1'b1, 1'b0};
        int n;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bo.bin = vals[k]; bo.in_valid = 1'b1; bo.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bo.in_valid = 1'b0;
            n = 0;
            while (!bo.out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            n_run++; if (bo.bcd !== expb[k] || bo.ovf !== expo[k]) begin n_fail++; $display("FAIL ovf[%0d] got bcd=%h ovf=%b want %h/%b", k, bo.bcd, bo.ovf, expb[k], expo[k]); end
        end
    endtask
`endif

    task automatic test_random16();
        int accepted = 0;
        int results  = 0;
        int n;
        int tmp;
        logic [15:0] v;
        logic [19:0] exp;
        for (int k = 0; k < 1000; k++) begin
            v = 16'($urandom_range(0, 65535));
            tmp = int'(v);
            for (int d = 0; d < 5; d++) begin
                exp[4*d +: 4] = 4'(tmp % 10);
                tmp = tmp / 10;
            end
            @(negedge clk);
            b16.bin = v; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
            @(posedge clk);
            accepted++;
            @(negedge clk);
            b16.in_valid = 1'b0;
            n = 0;
            while (!b16.out_valid && n < 100) begin
                b16.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            b16.out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (b16.out_valid) results++;
            n_run++; if (b16.bcd !== exp || b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL rand16 v=%0d got bcd=%h ov=%b want %h/1", v, b16.bcd, b16.out_valid, exp); end
            b16.out_ready = 1'b1;
            @(negedge clk);
            b16.out_ready = 1'b0;
            n_run++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand16_drop v=%0d got ov=%b want 0", v, b16.out_valid); end
        end
        n_run++; if (results !== accepted) begin n_fail++; $display("FAIL rand16_count got %0d want %0d", results, accepted); end
    endtask

    initial begin
        b8.in_valid  = 1'b0; b8.bin  = '0; b8.out_ready  = 1'b0;
        b4.in_valid  = 1'b0; b4.bin  = '0; b4.out_ready  = 1'b0;
        b16.in_valid = 1'b0; b16.bin = '0; b16.out_ready = 1'b0;
`ifdef BIN2BCD_OVF_EN
        bo.in_valid  = 1'b0; bo.bin  = '0; bo.out_ready  = 1'b0;
`endif
        test_reset();
        test_basic();
        test_sweep4();
        test_backpressure();
        test_reset_mid();
`ifdef BIN2BCD_OVF_EN
        test_overflow();
`endif
        test_random16();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
